// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: a valid/ready start launches N pulses of
// act_cycles active level separated by gap_cycles idle level, with abort and done strobe.
module pulse_train_gen #(
  parameter int   CNT_W      = 8,
  parameter int   WID_W      = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [WID_W-1:0] act_cycles,
  input  logic [WID_W-1:0] gap_cycles,
  input  logic             abort,
  output logic             signal_out,
  output logic             busy,
  output logic             done_pulse,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam logic [WID_W-1:0] WID_ONE = {{(WID_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WID_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [WID_W-1:0] act_q, act_d;
  logic [WID_W-1:0] gap_q, gap_d;
  logic             sig_q, sig_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [WID_W-1:0] act_eff_s;
  logic [WID_W-1:0] gap_eff_s;

  // Zero-length phases are promoted to one cycle at the moment they are latched
  assign act_eff_s = (act_cycles == {WID_W{1'b0}}) ? WID_ONE : act_cycles;
  assign gap_eff_s = (gap_cycles == {WID_W{1'b0}}) ? WID_ONE : gap_cycles;

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign signal_out  = sig_q;
  assign done_pulse  = done_q;
  assign aborted     = aborted_q;

  // Next-state and registered-output computation; phase_q counts cycles left including the current one
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pulse_d   = pulse_q;
    act_d     = act_q;
    gap_d     = gap_q;
    sig_d     = IDLE_LEVEL;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          act_d   = act_eff_s;
          gap_d   = gap_eff_s;
          pulse_d = num_pulses;
          if (num_pulses == {CNT_W{1'b0}}) begin
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end else begin
            state_d = S_ACTIVE;
            phase_d = act_eff_s;
            sig_d   = ~IDLE_LEVEL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (phase_q == WID_ONE) begin
          pulse_d = pulse_q - CNT_ONE;
          if (pulse_q == CNT_ONE) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end else begin
            state_d = S_GAP;
            phase_d = gap_q;
          end
        end else begin
          phase_d = phase_q - WID_ONE;
          sig_d   = ~IDLE_LEVEL;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (phase_q == WID_ONE) begin
          state_d = S_ACTIVE;
          phase_d = act_q;
          sig_d   = ~IDLE_LEVEL;
        end else begin
          phase_d = phase_q - WID_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= {WID_W{1'b0}};
      pulse_q   <= {CNT_W{1'b0}};
      act_q     <= {WID_W{1'b0}};
      gap_q     <= {WID_W{1'b0}};
      sig_q     <= IDLE_LEVEL;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pulse_q   <= pulse_d;
      act_q     <= act_d;
      gap_q     <= gap_d;
      sig_q     <= sig_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: each accepted start expands into a per-cycle queue of
// expected outputs built from the train-shape rules; abort and reset rewrite it.
module tb_pulse_train_gen;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  num_pulses;
  logic [15:0] act_cycles;
  logic [15:0] gap_cycles;
  logic        abort;
  logic        signal_out;
  logic        busy;
  logic        done_pulse;
  logic        aborted;

  pulse_train_gen #(.CNT_W(8), .WID_W(16), .IDLE_LEVEL(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .num_pulses  (num_pulses),
    .act_cycles  (act_cycles),
    .gap_cycles  (gap_cycles),
    .abort       (abort),
    .signal_out  (signal_out),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .aborted     (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic sig;
    logic bsy;
    logic dn;
    logic ab;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic ab_exp;
  int   n_checks;
  int   n_errors;
  int   fall_cnt;
  int   train_n;
  logic prev_sig;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, observe after the edge
  task automatic step(input logic sv, input int n, input int a, input int g,
                      input logic ab, input logic rn);
    int ae;
    int ge;
    start_valid = sv;
    num_pulses  = n[7:0];
    act_cycles  = a[15:0];
    gap_cycles  = g[15:0];
    abort       = ab;
    rst_n       = rn;
    if (!rn) begin
      exp_q.delete();
      cur    = '{sig: 1'b1, bsy: 1'b0, dn: 1'b0, ab: 1'b0};
      ab_exp = 1'b0;
      train_n = -1;
    end else if (cur.bsy && ab) begin
      exp_q.delete();
      cur    = '{sig: 1'b1, bsy: 1'b0, dn: 1'b1, ab: 1'b1};
      ab_exp = 1'b1;
    end else begin
      if (!cur.bsy && sv) begin
        ae = (a[15:0] == 16'd0) ? 1 : int'(a[15:0]);
        ge = (g[15:0] == 16'd0) ? 1 : int'(g[15:0]);
        exp_q.delete();
        for (int p = 0; p < n[7:0]; p++) begin
          for (int c = 0; c < ae; c++) exp_q.push_back('{sig: 1'b0, bsy: 1'b1, dn: 1'b0, ab: 1'b0});
          if (p < n[7:0] - 1)
            for (int c = 0; c < ge; c++) exp_q.push_back('{sig: 1'b1, bsy: 1'b1, dn: 1'b0, ab: 1'b0});
        end
        exp_q.push_back('{sig: 1'b1, bsy: 1'b0, dn: 1'b1, ab: 1'b0});
        fall_cnt = 0;
        train_n  = int'(n[7:0]);
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{sig: 1'b1, bsy: 1'b0, dn: 1'b0, ab: 1'b0};
      if (cur.dn) ab_exp = cur.ab;
    end
    @(posedge clk);
    #1;
    check("signal_out", {31'd0, signal_out}, {31'd0, cur.sig});
    check("busy", {31'd0, busy}, {31'd0, cur.bsy});
    check("start_ready", {31'd0, start_ready}, {31'd0, ~cur.bsy});
    check("done_pulse", {31'd0, done_pulse}, {31'd0, cur.dn});
    check("aborted", {31'd0, aborted}, {31'd0, ab_exp});
    if (prev_sig === 1'b1 && signal_out === 1'b0) fall_cnt++;
    prev_sig = signal_out;
    if (cur.dn && !cur.ab && train_n >= 0) check("loopback_pulses", fall_cnt, train_n);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    fall_cnt = 0;
    train_n  = -1;
    prev_sig = 1'b1;
    ab_exp   = 1'b0;
    cur      = '{sig: 1'b1, bsy: 1'b0, dn: 1'b0, ab: 1'b0};
    start_valid = 1'b0; num_pulses = 8'd0; act_cycles = 16'd0; gap_cycles = 16'd0;
    abort = 1'b0; rst_n = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle(2);

    // Basic train, then back-to-back start in its done cycle 13
    step(1'b1, 3, 2, 3, 1'b0, 1'b1);
    idle(12);
    step(1'b1, 3, 2, 3, 1'b0, 1'b1);
    idle(14);

    // Zero count, zero widths, maximum count
    step(1'b1, 0, 4, 4, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 2, 0, 0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 255, 1, 1, 1'b0, 1'b1);
    idle(511);

    // Abort at cycle 3, then abort while idle is ignored
    step(1'b1, 4, 5, 5, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    idle(4);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    step(1'b1, 1, 2, 2, 1'b1, 1'b1);
    idle(4);

    // Start held high with changed fields during a train
    step(1'b1, 2, 3, 2, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 7, 1, 9, 1'b0, 1'b1);
    idle(16);

    // Reset mid-gap at cycle 4 of the basic train
    step(1'b1, 3, 2, 3, 1'b0, 1'b1);
    idle(3);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
